tristate_line_rx: RTL and testbench

Serial receiver at the far end of a shared single-wire line driven by tristate buffers. It samples the line on a single clock, detects a start bit, recovers 8 data bits LSB-first, checks the stop bit, and presents each byte with a one-cycle valid pulse. An undriven line reads as logic 1 through a bus pull-up, so "no driver enabled" is the idle state.

---
 rtl/tristate_bus_pkg.sv | 20 ++
 rtl/rx_bit_timer.sv | 32 +++
 rtl/tristate_line_rx.sv | 135 +++++++++++++
 tb/tb_tristate_line_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
// rtl/tristate_bus_pkg.sv - shared constants for the tristate line receiver and transmitter.
// Optional parity is selected by TRISTATE_RX_PARITY_EN in the users of this package.
package tristate_bus_pkg;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    // Parity bit that makes the total count of ones across data+parity even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - per-bit cycle counter with clear, mid-bit and end-of-bit ticks.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

    assign half_tick = (count == HALF);
    assign full_tick = (count == LAST);

endmodule

// File: rtl/tristate_line_rx.sv
// rtl/tristate_line_rx.sv - single-wire pulled-up line receiver, 8N1 or 8E1 with TRISTATE_RX_PARITY_EN.
module tristate_line_rx
    import tristate_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              parity_err
);

    logic              sync_ff;
    logic              line_s;
    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              timer_clr;
    logic              half_tick;
    logic              full_tick;
`ifdef TRISTATE_RX_PARITY_EN
    logic              par_bad;
`endif

    // Synchronizer resets to the idle (pulled-up) level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 1'b1;
            line_s  <= 1'b1;
        end else begin
            sync_ff <= line_in;
            line_s  <= sync_ff;
        end
    end

    // Timer is re-phased at the falling edge and again at mid-start, so later full ticks land mid-bit.
    assign timer_clr = (state == IDLE) || ((state == START) && half_tick);

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef TRISTATE_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef TRISTATE_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!line_s) state <= START;
                end
                START: begin
                    bit_cnt <= 3'd0;
`ifdef TRISTATE_RX_PARITY_EN
                    par_bad <= 1'b0;
`endif
                    if (half_tick) state <= line_s ? IDLE : DATA;
                end
                DATA: begin
                    if (full_tick) begin
                        shift_reg <= {line_s, shift_reg[DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_W - 1)) begin
`ifdef TRISTATE_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef TRISTATE_RX_PARITY_EN
                PARITY: begin
                    if (full_tick) begin
                        par_bad <= (line_s != even_parity(shift_reg));
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (full_tick) begin
                        if (line_s) begin
`ifdef TRISTATE_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end
`else
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (line_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef TRISTATE_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_line_rx.sv
// tb/tb_tristate_line_rx.sv - directed and random frames driven onto a pulled-up tristate net.
module tb_tristate_line_rx;

    localparam int CPB = 16;
`ifdef TRISTATE_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       drv_en;
    logic       drv_val;
    tri1        line;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;

    assign line = drv_en ? drv_val : 1'bz;

    tristate_line_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line_in   (line),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: byte/cycle of each data_valid, error counts, overlap and stretched-pulse counts.
    int   dv_q[$];
    int   dv_cyc[$];
    int   fe_n = 0;
    int   pe_n = 0;
    int   overlap_n = 0;
    int   long_n = 0;
    logic prev_dv = 1'b0;
    logic prev_fe = 1'b0;
    logic prev_pe = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                dv_q.push_back(int'(data_out));
                dv_cyc.push_back(cyc);
            end
            if (frame_err) fe_n++;
            if (parity_err) pe_n++;
            if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) overlap_n++;
            if ((data_valid && prev_dv) || (frame_err && prev_fe) || (parity_err && prev_pe)) long_n++;
        end
        prev_dv = data_valid;
        prev_fe = frame_err;
        prev_pe = parity_err;
    end

    int total = 0;
    int bad = 0;
    int base_dv, base_fe, base_pe, rd;
    int frame_t0;
`ifdef TRISTATE_RX_PARITY_EN
    bit par_flip = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        drv_en  = 1'b1;
        drv_val = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drv_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        frame_t0 = cyc;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef TRISTATE_RX_PARITY_EN
        drive((^b) ^ par_flip, CPB);
`endif
        drive(stop_v, stop_len);
    endtask

    task automatic mark();
        base_dv = dv_q.size();
        base_fe = fe_n;
        base_pe = pe_n;
        rd      = base_dv;
    endtask

    function automatic logic [31:0] next_dv();
        if (rd < dv_q.size()) begin
            rd++;
            return 32'(dv_q[rd-1]);
        end
        return 32'hFFFF_FFFF;
    endfunction

    int          exp_q[$];
    int          exp_fe;
    logic [7:0]  rb;
    logic        rbad;
    int          last_good;

    initial begin
        rst     = 1'b1;
        drv_en  = 1'b0;
        drv_val = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_parity_err", 32'(parity_err), 32'h0);
        rst = 1'b0;
        idle(6);

        // Single frame with latency from the start edge
        mark();
        send_frame(8'hA5, 1'b1, CPB);
        idle(4);
        chk("a5_pulses", 32'(dv_q.size() - base_dv), 32'd1);
        chk("a5_latency", (dv_q.size() > base_dv) ? 32'(dv_cyc[base_dv] - frame_t0) : 32'hFFFF_FFFF, 32'(LAT));
        chk("a5_data", next_dv(), 32'hA5);
        chk("a5_data_out_held", 32'(data_out), 32'hA5);

        // Short low glitch is ignored
        mark();
        drive(1'b0, 4);
        idle(40);
        chk("glitch_no_valid", 32'(dv_q.size() - base_dv), 32'd0);
        chk("glitch_no_ferr", 32'(fe_n - base_fe), 32'd0);
        send_frame(8'h3C, 1'b1, CPB);
        idle(4);
        chk("3c_pulses", 32'(dv_q.size() - base_dv), 32'd1);
        chk("3c_data", next_dv(), 32'h3C);

        // Stop held low: frame error, no retrigger while stuck low
        mark();
        send_frame(8'h5A, 1'b0, 40);
        chk("5a_frame_err", 32'(fe_n - base_fe), 32'd1);
        chk("5a_no_valid", 32'(dv_q.size() - base_dv), 32'd0);
        chk("5a_data_out_kept", 32'(data_out), 32'h3C);
        idle(8);
        send_frame(8'h81, 1'b1, CPB);
        idle(4);
        chk("81_pulses", 32'(dv_q.size() - base_dv), 32'd1);
        chk("81_data", next_dv(), 32'h81);
        chk("81_no_extra_ferr", 32'(fe_n - base_fe), 32'd1);

        // Back-to-back frames, no idle gap
        mark();
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        idle(4);
        chk("b2b_pulses", 32'(dv_q.size() - base_dv), 32'd2);
        chk("b2b_first", next_dv(), 32'h00);
        chk("b2b_second", next_dv(), 32'hFF);
        chk("b2b_spacing", (dv_q.size() >= base_dv + 2) ? 32'(dv_cyc[base_dv+1] - dv_cyc[base_dv]) : 32'hFFFF_FFFF,
            32'(CPB * (10 + (LAT - (2 + CPB / 2 + 9 * CPB + 1)) / CPB)));

        // Reset in the middle of data bit 4 of 8'hF0
        mark();
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(1'b0, CPB);
        drive(1'b1, CPB / 2);
        rst = 1'b1;
        drive(1'b1, 1);
        rst = 1'b0;
        chk("midreset_data_out", 32'(data_out), 32'h0);
        drive(1'b1, CPB / 2 - 1);
        for (int i = 0; i < 3; i++) drive(1'b1, CPB);
`ifdef TRISTATE_RX_PARITY_EN
        drive(1'b0, CPB);
`endif
        drive(1'b1, CPB);
        idle(4);
        chk("midreset_no_valid", 32'(dv_q.size() - base_dv), 32'd0);
        chk("midreset_no_ferr", 32'(fe_n - base_fe), 32'd0);
        send_frame(8'h0F, 1'b1, CPB);
        idle(4);
        chk("0f_data", next_dv(), 32'h0F);

`ifdef TRISTATE_RX_PARITY_EN
        mark();
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1, CPB);
        idle(4);
        chk("par_bad_err", 32'(pe_n - base_pe), 32'd1);
        chk("par_bad_no_valid", 32'(dv_q.size() - base_dv), 32'd0);
        chk("par_bad_data_kept", 32'(data_out), 32'h0F);
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1, CPB);
        idle(4);
        chk("par_good_valid", 32'(dv_q.size() - base_dv), 32'd1);
        chk("par_good_data", next_dv(), 32'h03);
`endif

        // Random frames: model keeps the list of bytes that must arrive and the error count
        mark();
        exp_fe    = 0;
        last_good = 32'h0F;
`ifdef TRISTATE_RX_PARITY_EN
        last_good = 32'h03;
`endif
        for (int n = 0; n < 24; n++) begin
            rb   = 8'($urandom);
            rbad = ($urandom_range(0, 5) == 0);
            send_frame(rb, !rbad, CPB);
            if (rbad) begin
                exp_fe++;
                idle($urandom_range(4, 20));
            end else begin
                exp_q.push_back(int'(rb));
                last_good = int'(rb);
                idle($urandom_range(0, 20));
            end
        end
        idle(8);
        chk("rand_count", 32'(dv_q.size() - base_dv), 32'(exp_q.size()));
        foreach (exp_q[k]) chk($sformatf("rand_byte_%0d", k), next_dv(), 32'(exp_q[k]));
        chk("rand_frame_errs", 32'(fe_n - base_fe), 32'(exp_fe));
        chk("rand_last_data_out", 32'(data_out), 32'(last_good));

        chk("pulses_exclusive", 32'(overlap_n), 32'd0);
        chk("pulses_one_cycle", 32'(long_n), 32'd0);
`ifndef TRISTATE_RX_PARITY_EN
        chk("parity_err_never", 32'(pe_n), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
